// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO multiply/divide controller.
// Sequences MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring divide),
// one bit per cycle, plus the single-cycle MTHI/MTLO and divide-by-zero
// paths. The finished result is presented with a one-cycle write strobe.
module muldiv_hilo_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opdata1,
  input  logic [XLEN-1:0] opdata2,
  input  logic            annul,
  input  logic [XLEN-1:0] hi_cur,
  input  logic [XLEN-1:0] lo_cur,
  output logic            stall_o,
  output logic            hilo_we,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem, quo, dvsr;
  logic              neg_res, neg_rem;

  // Operation decode, only meaningful while IDLE
  logic is_mul, is_div, is_signed, div_zero, accept_long, accept_short;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_mul    = (op == 3'b001) || (op == 3'b010);
  assign is_div    = (op == 3'b011) || (op == 3'b100);
  assign is_signed = (op == 3'b001) || (op == 3'b011);
  assign div_zero  = (opdata2 == '0);

  assign accept_long  = (state == S_IDLE) && start && !annul &&
                        (is_mul || (is_div && !div_zero));
  assign accept_short = (state == S_IDLE) && start && !annul &&
                        ((is_div && div_zero) || (op == 3'b101) || (op == 3'b110));

  // Signed operations iterate on magnitudes; the signs are restored at the end
  assign a_mag = (is_signed && opdata1[XLEN-1]) ? -opdata1 : opdata1;
  assign b_mag = (is_signed && opdata2[XLEN-1]) ? -opdata2 : opdata2;

  // One iteration of each datapath, plus the sign-corrected final values
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   rem_step, quo_step, rem_fix, quo_fix;
  logic              last;

  assign prod_step = prod + (mplier[0] ? mcand : '0);
  assign div_sh    = {rem, quo[XLEN-1]};
  assign div_diff  = div_sh - {1'b0, dvsr};
  assign rem_step  = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
  assign quo_step  = {quo[XLEN-2:0], ~div_diff[XLEN]};
  assign prod_fix  = neg_res ? -prod_step : prod_step;
  assign quo_fix   = neg_res ? -quo_step : quo_step;
  assign rem_fix   = neg_rem ? -rem_step : rem_step;
  assign last      = (cnt == CW'(XLEN - 1));

  assign hilo_we = (state == S_DONE);
  assign busy    = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and combinational stall request
  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_long) begin
          stall_o  = 1'b1;
          state_nx = is_mul ? S_MUL : S_DIV;
        end else if (accept_short) begin
          state_nx = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        stall_o = 1'b1;
        if (annul)     state_nx = S_IDLE;
        else if (last) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  // Operand latching, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept_long) begin
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, a_mag};
            mplier  <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            dvsr    <= b_mag;
            neg_res <= is_signed && (opdata1[XLEN-1] ^ opdata2[XLEN-1]);
            neg_rem <= is_signed && opdata1[XLEN-1];
          end else if (accept_short) begin
            if (is_div) begin
              hi_o <= opdata1;
              lo_o <= '1;
            end else if (op == 3'b101) begin
              hi_o <= opdata1;
              lo_o <= lo_cur;
            end else begin
              hi_o <= hi_cur;
              lo_o <= opdata1;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last && !annul) begin
            hi_o <= prod_fix[2*XLEN-1:XLEN];
            lo_o <= prod_fix[XLEN-1:0];
          end
        end
        S_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
          if (last && !annul) begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: a table of directed operations
// with hand-computed results and latencies, plus hand-written sequences for
// reset, annul and start-while-busy behaviour.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [2:0]  op;
  logic [31:0] opdata1, opdata2, hi_cur, lo_cur;
  logic        stall_o, hilo_we, busy;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  muldiv_hilo_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .hi_cur(hi_cur), .lo_cur(lo_cur), .stall_o(stall_o),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hc, lc;
    logic [31:0] exp_hi, exp_lo;
    int          exp_lat;
    int          exp_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to its write strobe (bounded wait)
  task automatic run_op(input vec_t v, input int idx);
    int n, stalls;
    @(negedge clk);
    start = 1'b1; op = v.op; opdata1 = v.a; opdata2 = v.b;
    hi_cur = v.hc; lo_cur = v.lc;
    #1;
    stalls = stall_o ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!hilo_we && n < 45) begin
      if (stall_o) stalls++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d latency", idx), 64'(n), 64'(v.exp_lat));
    chk($sformatf("v%0d stalls", idx), 64'(stalls), 64'(v.exp_stall));
    chk($sformatf("v%0d result", idx), {hi_o, lo_o}, {v.exp_hi, v.exp_lo});
    chk($sformatf("v%0d stall_in_done", idx), 64'(stall_o), 64'd0);
    $display("v%0d op=%0d a=%h b=%h -> we@%0d hi=%h lo=%h", idx, v.op, v.a, v.b, n, hi_o, lo_o);
    @(negedge clk);
    chk($sformatf("v%0d we_pulse", idx), {63'd0, hilo_we}, 64'd0);
    chk($sformatf("v%0d idle_after", idx), {63'd0, busy}, 64'd0);
    chk($sformatf("v%0d hold", idx), {hi_o, lo_o}, {v.exp_hi, v.exp_lo});
  endtask

  initial begin
    int pulses;
    //            op      a             b             hi_cur        lo_cur        hi            lo            lat stall
    vecs[0]  = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 33, 33};
    vecs[1]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 33, 33};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h00000001, 33, 33};
    vecs[3]  = '{3'b001, 32'h80000000, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000000, 33, 33};
    vecs[4]  = '{3'b010, 32'h12345678, 32'h00000010, 32'h0,        32'h0,        32'h00000001, 32'h23456780, 33, 33};
    vecs[5]  = '{3'b100, 32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       33, 33};
    vecs[6]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
    vecs[7]  = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 33, 33};
    vecs[8]  = '{3'b011, 32'hFFFFFFF8, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFE, 33, 33};
    vecs[9]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'h00000000, 32'hFFFFFFFF, 33, 33};
    vecs[10] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 33, 33};
    vecs[11] = '{3'b011, 32'd5,        32'd0,        32'h0,        32'h0,        32'd5,        32'hFFFFFFFF, 1,  0};
    vecs[12] = '{3'b101, 32'h12345678, 32'h0,        32'h0,        32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 1,  0};
    vecs[13] = '{3'b110, 32'hCAFEBABE, 32'h0,        32'h0BADF00D, 32'h0,        32'h0BADF00D, 32'hCAFEBABE, 1,  0};

    rst = 1'b1; start = 1'b1; op = 3'b001; annul = 1'b0;
    opdata1 = 32'd3; opdata2 = 32'd3; hi_cur = '0; lo_cur = '0;
    repeat (3) @(negedge clk);
    chk("reset stall", {63'd0, stall_o}, 64'd0);
    chk("reset we_busy", {62'd0, hilo_we, busy}, 64'd0);
    chk("reset hilo", {hi_o, lo_o}, 64'd0);
    $display("reset: stall=%b we=%b busy=%b hi=%h lo=%h", stall_o, hilo_we, busy, hi_o, lo_o);
    rst = 1'b0; start = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], i);

    // op none is ignored
    @(negedge clk);
    start = 1'b1; op = 3'b000; #1;
    chk("opnone stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("opnone busy", {62'd0, busy, hilo_we}, 64'd0);
    $display("op none: busy=%b we=%b", busy, hilo_we);

    // annul in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1; op = 3'b101; opdata1 = 32'h55555555; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    chk("annul_idle we_busy", {62'd0, hilo_we, busy}, 64'd0);
    $display("annul in idle: we=%b busy=%b", hilo_we, busy);

    // annul in DONE does not suppress the write
    @(negedge clk);
    start = 1'b1; op = 3'b110; opdata1 = 32'h0000BEEF; hi_cur = 32'h00001111;
    @(negedge clk);
    start = 1'b0; annul = 1'b1; #1;
    chk("annul_done we", {63'd0, hilo_we}, 64'd1);
    chk("annul_done data", {hi_o, lo_o}, {32'h00001111, 32'h0000BEEF});
    $display("annul in done: we=%b hi=%h lo=%h", hilo_we, hi_o, lo_o);
    @(negedge clk);
    annul = 1'b0;

    // MULTU annulled at iteration 10, then a DIVU completes normally
    @(negedge clk);
    start = 1'b1; op = 3'b010; opdata1 = 32'd9; opdata2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_mul busy", {62'd0, busy, stall_o}, 64'd0);
    pulses = 0;
    repeat (40) begin
      if (hilo_we) pulses++;
      @(negedge clk);
    end
    chk("annul_mul no_write", 64'(pulses), 64'd0);
    chk("annul_mul hilo_kept", {hi_o, lo_o}, {32'h00001111, 32'h0000BEEF});
    $display("annul mul: busy=%b writes=%0d", busy, pulses);
    run_op(vecs[5], 100);

    // DIVU reset at iteration 20
    @(negedge clk);
    start = 1'b1; op = 3'b100; opdata1 = 32'd1000; opdata2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid outputs", {hi_o, lo_o}, 64'd0);
    chk("rst_mid flags", {61'd0, busy, hilo_we, stall_o}, 64'd0);
    pulses = 0;
    repeat (40) begin
      if (hilo_we) pulses++;
      @(negedge clk);
    end
    chk("rst_mid no_write", 64'(pulses), 64'd0);
    $display("reset mid divide: hi=%h lo=%h writes=%0d", hi_o, lo_o, pulses);

    // start while busy is ignored: exactly one result from the MULT
    @(negedge clk);
    start = 1'b1; op = 3'b001; opdata1 = 32'd6; opdata2 = 32'd7;
    @(negedge clk);
    op = 3'b101; opdata1 = 32'hDEADBEEF;
    repeat (5) @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (45) begin
      if (hilo_we) pulses++;
      @(negedge clk);
    end
    chk("busy_start writes", 64'(pulses), 64'd1);
    chk("busy_start result", {hi_o, lo_o}, {32'd0, 32'd42});
    $display("start while busy: writes=%0d hi=%h lo=%h", pulses, hi_o, lo_o);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
